// File: rtl/lcd_dither_444_if.sv
// lcd_dither_444_if: generator-side RGB565 pixel/timing inputs and panel-side RGB444 outputs.
interface lcd_dither_444_if;
  logic DE_in, HSYNC_in, VSYNC_in;
  logic [4:0] R_in;
  logic [5:0] G_in;
  logic [4:0] B_in;
  logic LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [3:0] LCD_R, LCD_G, LCD_B;
  logic line_err;
  modport master (
    output DE_in, HSYNC_in, VSYNC_in, R_in, G_in, B_in,
    input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, line_err
  );
  modport slave (
    input  DE_in, HSYNC_in, VSYNC_in, R_in, G_in, B_in,
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, line_err
  );
endinterface

// File: rtl/lcd_dither_444.sv
// lcd_dither_444: 4x4 Bayer ordered dither RGB565 -> RGB444 with 2-cycle aligned timing.
// Define LCD_DITHER_FRC_EN to rotate the pattern by a per-frame counter.
module lcd_dither_444 #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter bit SYNC_ACTIVE_LOW = 1
) (
  input logic PixelClk,
  input logic RST,
  lcd_dither_444_if.slave io
);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };
  logic [8:0] col, row;
  logic de_q, vs_q, vs_act, vs_edge, de_fall, err;
  logic [1:0] f, ri, ci, t_hi;
  logic s1_de, s1_hs, s1_vs, s1_err;
  logic [4:0] s1_r, s1_b;
  logic [5:0] s1_g;
  logic [1:0] s1_t;
  logic [5:0] sum_r, sum_b;
  logic [6:0] sum_g;
  logic [3:0] q_r, q_g, q_b;
  always_comb begin
    vs_act = SYNC_ACTIVE_LOW ? ~io.VSYNC_in : io.VSYNC_in;
    vs_edge = vs_act & ~vs_q;
    de_fall = de_q & ~io.DE_in;
    err = de_fall && col != 9'(H_ACTIVE);
    ri = row[1:0] + f;
    ci = col[1:0] + f;
    t_hi = BAYER[{ri, ci}][3:2];
    sum_r = {1'b0, s1_r} + 6'(s1_t[1]);
    sum_b = {1'b0, s1_b} + 6'(s1_t[1]);
    sum_g = {1'b0, s1_g} + 7'(s1_t);
    q_r = sum_r[5] ? 4'hF : sum_r[4:1];
    q_b = sum_b[5] ? 4'hF : sum_b[4:1];
    q_g = sum_g[6] ? 4'hF : sum_g[5:2];
  end
`ifdef LCD_DITHER_FRC_EN
  always_ff @(posedge PixelClk)
    f <= RST ? 2'd0 : f + 2'(vs_edge);
`else
  assign f = 2'd0;
`endif
  // Row clear on the VSYNC edge takes priority over a coincident DE fall.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      col <= '0;
      row <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= io.DE_in;
      vs_q <= vs_act;
      col <= !io.DE_in ? '0 : (col == 9'(H_ACTIVE + 1) ? col : col + 9'd1);
      row <= vs_edge ? '0 : (de_fall && row != 9'(V_ACTIVE) ? row + 9'd1 : row);
    end
  end
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      s1_de <= 1'b0;
      s1_hs <= SYNC_IDLE;
      s1_vs <= SYNC_IDLE;
      s1_err <= 1'b0;
      s1_r <= '0;
      s1_g <= '0;
      s1_b <= '0;
      s1_t <= '0;
      io.LCD_DE <= 1'b0;
      io.LCD_HSYNC <= SYNC_IDLE;
      io.LCD_VSYNC <= SYNC_IDLE;
      io.LCD_R <= '0;
      io.LCD_G <= '0;
      io.LCD_B <= '0;
      io.line_err <= 1'b0;
    end else begin
      s1_de <= io.DE_in;
      s1_hs <= io.HSYNC_in;
      s1_vs <= io.VSYNC_in;
      s1_err <= err;
      s1_r <= io.R_in;
      s1_g <= io.G_in;
      s1_b <= io.B_in;
      s1_t <= t_hi;
      io.LCD_DE <= s1_de;
      io.LCD_HSYNC <= s1_hs;
      io.LCD_VSYNC <= s1_vs;
      io.LCD_R <= s1_de ? q_r : '0;
      io.LCD_G <= s1_de ? q_g : '0;
      io.LCD_B <= s1_de ? q_b : '0;
      io.line_err <= s1_err;
    end
  end
endmodule

// File: tb/tb_lcd_dither_444.sv
// tb_lcd_dither_444: scoreboard bench; driver pushes per-cycle expected outputs, monitor pops 2 cycles later.
module tb_lcd_dither_444;
  logic PixelClk = 1'b0;
  logic RST = 1'b1;
  always #5 PixelClk = ~PixelClk;
  lcd_dither_444_if io ();
  lcd_dither_444 dut (.PixelClk(PixelClk), .RST(RST), .io(io));
  typedef struct packed {
    logic de, hs, vs;
    logic [3:0] r, g, b;
    logic err;
  } out_t;
  localparam out_t RST_VAL = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
`ifdef LCD_DITHER_FRC_EN
  localparam bit FRC = 1'b1;
`else
  localparam bit FRC = 1'b0;
`endif
  int mtx [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  out_t exp_q [$];
  int checks = 0, errors = 0;
  int m_col, m_row, m_f;
  logic m_deq, m_vsq;
  logic r_s = 1'b1;
  function automatic logic [3:0] q5(int v, int t);
    int s = v + t / 8;
    return 4'((s > 31 ? 31 : s) / 2);
  endfunction
  function automatic logic [3:0] q6(int v, int t);
    int s = v + t / 4;
    return 4'((s > 63 ? 63 : s) / 4);
  endfunction
  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [4:0] r,
                     input logic [5:0] g, input logic [4:0] b, input bit hand = 1'b0,
                     input logic [3:0] hr = 4'h0, input logic [3:0] hg = 4'h0, input logic [3:0] hb = 4'h0);
    out_t e;
    int t;
    logic vact, ve, fall;
    io.DE_in = de;
    io.HSYNC_in = hs;
    io.VSYNC_in = vs;
    io.R_in = r;
    io.G_in = g;
    io.B_in = b;
    vact = ~vs;
    ve = vact & ~m_vsq;
    fall = m_deq & ~de;
    t = mtx[(m_row + m_f) % 4][(m_col + m_f) % 4];
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    e.r = de ? q5(r, t) : 4'h0;
    e.g = de ? q6(g, t) : 4'h0;
    e.b = de ? q5(b, t) : 4'h0;
    if (hand) begin
      e.r = hr;
      e.g = hg;
      e.b = hb;
    end
    e.err = fall && m_col != 480;
    exp_q.push_back(e);
    m_col = de ? (m_col < 481 ? m_col + 1 : 481) : 0;
    m_row = ve ? 0 : ((fall && m_row < 272) ? m_row + 1 : m_row);
    if (ve && FRC) m_f = (m_f + 1) % 4;
    m_deq = de;
    m_vsq = vact;
    @(posedge PixelClk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b1, 5'h0, 6'h0, 5'h0);
  endtask
  task automatic hgap();
    idle(1);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 5'h0, 6'h0, 5'h0);
    idle(1);
  endtask
  task automatic vpulse();
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 5'h0, 6'h0, 5'h0);
    idle(2);
  endtask
  task automatic do_reset(int n);
    RST = 1'b1;
    io.DE_in = 1'b1;
    io.HSYNC_in = 1'b1;
    io.VSYNC_in = 1'b1;
    io.R_in = 5'h1F;
    io.G_in = 6'h3F;
    io.B_in = 5'h1F;
    repeat (n) @(posedge PixelClk);
    #1;
    RST = 1'b0;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    m_f = 0;
    m_deq = 1'b0;
    m_vsq = 1'b0;
    exp_q.push_back(RST_VAL);
  endtask
  always @(posedge PixelClk) r_s <= RST;
  always @(negedge PixelClk) begin
    out_t a, e;
    a = {io.LCD_DE, io.LCD_HSYNC, io.LCD_VSYNC, io.LCD_R, io.LCD_G, io.LCD_B, io.line_err};
    if (r_s) e = RST_VAL;
    else if (exp_q.size() == 0) e = ~a;
    else e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got de=%b hs=%b vs=%b r=%h g=%h b=%h err=%b exp de=%b hs=%b vs=%b r=%h g=%h b=%h err=%b",
               r_s ? "reset" : "pipe", $time, a.de, a.hs, a.vs, a.r, a.g, a.b, a.err,
               e.de, e.hs, e.vs, e.r, e.g, e.b, e.err);
    end
  end
  initial begin
    int lens [3] = '{479, 481, 480};
    do_reset(4);
    idle(3);
    hgap();
    vpulse();
    repeat (480) cyc(1'b1, 1'b1, 1'b1, 5'h1F, 6'h3F, 5'h1F);
    hgap();
    vpulse();
    cyc(1'b1, 1'b1, 1'b1, 5'h01, 6'h02, 5'h03, !FRC, 4'h0, 4'h0, 4'h1);
    cyc(1'b1, 1'b1, 1'b1, 5'h01, 6'h02, 5'h03, !FRC, 4'h1, 4'h1, 4'h2);
    repeat (478) cyc(1'b1, 1'b1, 1'b1, 5'h01, 6'h02, 5'h03);
    hgap();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < lens[k]; i++) cyc(1'b1, 1'b1, 1'b1, 5'(i), 6'(i * 3), 5'(i + 7));
      hgap();
    end
    vpulse();
    repeat (275) begin
      repeat (2) cyc(1'b1, 1'b1, 1'b1, 5'h0B, 6'h15, 5'h06);
      idle(2);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 5'h0B, 6'h17, 5'h0E);
    hgap();
    do_reset(2);
    idle(2);
    vpulse();
    cyc(1'b1, 1'b1, 1'b1, 5'h00, 6'h03, 5'h00, 1'b1, 4'h0, FRC ? 4'h1 : 4'h0, 4'h0);
    idle(4);
    @(negedge PixelClk);
    #1;
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL drain got %0d pending entries exp 1", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_dither_444.md
# lcd_dither_444

Ordered-dither output stage between the 480x272 LCD timing/pattern generator and the panel pins. It takes the generator's RGB565 pixel stream plus DE/HSYNC/VSYNC and tracks pixel column and row from DE and VSYNC. It adds a 4x4 Bayer threshold, saturates, and truncates to the panel's RGB444. All control signals are delayed to stay aligned with the pixel data, and malformed line lengths are flagged.

## Interface
- `H_ACTIVE`, 480: active pixels per line (DE-high cycles).
- `V_ACTIVE`, 272: active lines per frame.
- `SYNC_ACTIVE_LOW`, 1: 1 means HSYNC/VSYNC are asserted low; 0 means asserted high.
- `PixelClk`  in  1  pixel clock; everything is on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `DE_in`, `HSYNC_in`, `VSYNC_in`  in  1 each  timing from the generator.
- `R_in`  in  5  red; `G_in`  in  6  green; `B_in`  in  5  blue.
- `LCD_DE`, `LCD_HSYNC`, `LCD_VSYNC`  out  1 each  delayed timing.
- `LCD_R`, `LCD_G`, `LCD_B`  out  4 each  dithered colour.
- `line_err`  out  1  one-cycle pulse when a DE run is not exactly `H_ACTIVE` long.

## Operation
- **Column counter `col` (9 bit):**
  - Cleared when `DE_in` is low.
  - Increments every `DE_in`-high cycle and saturates at `H_ACTIVE+1`.
  - The value used for a pixel is the count before the increment, so the first pixel is col 0.
- **Row counter `row` (9 bit):**
  - Cleared on the VSYNC_in assertion edge (inactive to active).
  - Increments on each `DE_in` falling edge and saturates at `V_ACTIVE`.
  - A VSYNC edge and a DE fall in the same cycle: the clear wins.
- **Threshold:** `t = M[row[1:0]][col[1:0]]`, with M rows {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
- **Per-channel arithmetic:**
  - R and B: `d = t[3]`, out = `min(in + d, 31) >> 1`.
  - G: `d = t[3:2]`, out = `min(in + d, 63) >> 2`.
  - The sum is one bit wider than the input; saturation happens before the shift.
- **Blanking:** when the delayed DE is low, `LCD_R/G/B` = 0.
- **`line_err`:**
  - Evaluated on each `DE_in` falling edge: pulses if `col != H_ACTIVE`.
  - A run of 0 length cannot occur, since a fall requires DE to have been high.
- **Reset mid-frame:**
  - Counters, pipeline and flags are cleared.
  - After release, row counting resumes from 0 regardless of frame position until the next VSYNC edge.

## Timing
- The pipeline is 2 stages:
  - Stage 1 registers inputs plus threshold.
  - Stage 2 registers the saturated, truncated colour and the delayed timing.
- Latency is exactly 2 cycles for DE, HSYNC, VSYNC and colour; all four outputs stay mutually aligned.
- `line_err` is high for one cycle, 2 cycles after the first cycle in which `DE_in` is sampled low following a high, so it coincides with the `LCD_DE` fall.
- **Reset values:**
  - `LCD_DE` = 0.
  - `LCD_HSYNC` and `LCD_VSYNC` = inactive level (1 if `SYNC_ACTIVE_LOW`, else 0).
  - `LCD_R/G/B` = 0, `line_err` = 0, counters = 0.
- No backpressure: one pixel is accepted every cycle.

## Configuration
- **`LCD_DITHER_FRC_EN` defined:**
  - A 2-bit frame counter `f` increments on each VSYNC_in assertion edge and is cleared by reset.
  - The threshold becomes `M[(row+f)[1:0]][(col+f)[1:0]]`, giving temporal rotation of the pattern.
- **Undefined:** no frame counter exists and `f` is 0.
- Latency and all other behaviour are identical in both builds.

## Test plan
1. **Reset:**
   - Stimulus: hold `RST` = 1 for 4 cycles with `DE_in` = 1 and colour all-ones.
   - Required: `LCD_DE` = 0, `LCD_HSYNC` = `LCD_VSYNC` = 1, colour = 0, `line_err` = 0.
2. **Latency:**
   - Stimulus: `DE_in` rises at cycle N with `HSYNC_in` toggling at cycle M.
   - Required: `LCD_DE` rises at N+2 and `LCD_HSYNC` toggles at M+2.
3. **Saturation:**
   - Stimulus: R = 5'h1F, G = 6'h3F, B = 5'h1F across a full 480-pixel line.
   - Required: every output is 4'hF with no wrap to 0.
4. **Dither values, after a VSYNC edge (row 0):**
   - R = 5'h01 gives col 0 → 0 and col 1 → 1.
   - G = 6'h02 gives col 0 → 0 and col 1 → 1.
5. **Line errors:**
   - Stimulus: a 479-cycle DE run, then a 481-cycle run, then a 480-cycle run.
   - Required: a `line_err` pulse for the first two runs only, each one cycle long and aligned with the `LCD_DE` fall.
6. **FRC (macro defined):**
   - Stimulus: second frame after reset (f = 1), pixel (0,0), R = 5'h00, G = 6'h03.
   - Required: threshold M[1][1] = 4, so G = 1 and R = 0.
   - With the macro undefined, the same stimulus gives threshold 0, so G = 0.
